frame_plot_sequencer: RTL



---
 rtl/frame_plot_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/frame_plot_sequencer.sv
// Full-frame redraw sequencer: drives the screen counter, delays coordinates to meet the
// registered ROM colour, and issues VGA plot writes. Define PLOT_CLIP_EN to clip to VIS_W x VIS_H.
module frame_plot_sequencer #(
  parameter int ROM_LATENCY = 1,
  parameter int OVER_X0     = 40,
  parameter int OVER_Y0     = 40,
  parameter int VIS_W       = 160,
  parameter int VIS_H       = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [7:0]  src_x,
  input  logic [7:0]  src_y,
  input  logic [7:0]  game_x,
  input  logic [7:0]  game_y,
  input  logic        src_end,
  input  logic [23:0] colour_bg,
  input  logic [23:0] colour_start,
  input  logic [23:0] colour_over,
  output logic        draw_reset,
  output logic        draw_enable,
  output logic        draw_over,
  output logic [7:0]  vga_x,
  output logic [7:0]  vga_y,
  output logic [23:0] vga_colour,
  output logic        vga_plot,
  output logic        busy,
  output logic        done,
  output logic [15:0] plot_count
);

  localparam int       LP_LAST       = ROM_LATENCY - 1;
  localparam logic [1:0] LP_FLUSH_INIT = 2'(ROM_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [1:0]  r_mode;
  logic        r_first;
  logic [7:0]  r_last_gx;
  logic [7:0]  r_last_gy;
  logic [1:0]  r_flush_cnt;
  logic        r_draw_reset;
  logic        r_draw_enable;
  logic        r_draw_over;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_plot_count;

  logic [ROM_LATENCY-1:0] r_tag_dl;
  logic [7:0]             r_x_dl [ROM_LATENCY];
  logic [7:0]             r_y_dl [ROM_LATENCY];

  logic       w_over_mode;
  logic       w_run;
  logic       w_game_new;
  logic       w_tag;
  logic       w_in_vis;
  logic       w_plot_in;
  logic [7:0] w_x;
  logic [7:0] w_y;

  assign w_over_mode = (r_mode == 2'd2);
  assign w_run       = (r_state == S_RUN);
  // A stalled game counter repeats its coordinate; only fresh coordinates are drawn.
  assign w_game_new  = r_first || (game_x != r_last_gx) || (game_y != r_last_gy);
  assign w_tag       = w_run && !src_end && (!w_over_mode || w_game_new);
  assign w_x         = w_over_mode ? (game_x + OVER_X0[7:0]) : src_x;
  assign w_y         = w_over_mode ? (game_y + OVER_Y0[7:0]) : src_y;

`ifdef PLOT_CLIP_EN
  localparam logic [8:0] LP_VIS_W = 9'(VIS_W);
  localparam logic [8:0] LP_VIS_H = 9'(VIS_H);
  assign w_in_vis = ({1'b0, w_x} < LP_VIS_W) && ({1'b0, w_y} < LP_VIS_H);
`else
  logic w_unused_vis;
  assign w_unused_vis = ^{VIS_W, VIS_H};
  assign w_in_vis     = 1'b1;
`endif

  // Clipping depends only on the coordinate, so it is applied as the tag enters the delay line.
  assign w_plot_in = w_tag && w_in_vis;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_mode        <= 2'd0;
      r_first       <= 1'b0;
      r_flush_cnt   <= 2'd0;
      r_draw_reset  <= 1'b0;
      r_draw_enable <= 1'b0;
      r_draw_over   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_plot_count  <= 16'd0;
    end else begin
      r_draw_reset <= 1'b0;
      r_done       <= 1'b0;
      if (r_tag_dl[LP_LAST] && (r_plot_count != 16'hFFFF))
        r_plot_count <= r_plot_count + 16'd1;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_CLEAR;
            r_mode       <= mode;
            r_plot_count <= 16'd0;
            r_draw_reset <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_state       <= S_RUN;
          r_draw_enable <= 1'b1;
          r_draw_over   <= (r_mode == 2'd2);
          r_first       <= 1'b1;
        end
        S_RUN: begin
          r_first <= 1'b0;
          if (w_tag) begin
            r_last_gx <= game_x;
            r_last_gy <= game_y;
          end
          if (src_end) begin
            r_state       <= S_FLUSH;
            r_draw_enable <= 1'b0;
            r_draw_over   <= 1'b0;
            r_flush_cnt   <= LP_FLUSH_INIT;
          end
        end
        S_FLUSH: begin
          if (r_flush_cnt == 2'd0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_flush_cnt <= r_flush_cnt - 2'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Coordinate/tag delay line: stage LP_LAST lines up with the ROM colour.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag_dl <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) begin
        r_x_dl[i] <= 8'd0;
        r_y_dl[i] <= 8'd0;
      end
    end else begin
      r_tag_dl[0] <= w_plot_in;
      r_x_dl[0]   <= w_x;
      r_y_dl[0]   <= w_y;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        r_tag_dl[i] <= r_tag_dl[i-1];
        r_x_dl[i]   <= r_x_dl[i-1];
        r_y_dl[i]   <= r_y_dl[i-1];
      end
    end
  end

  assign draw_reset  = r_draw_reset;
  assign draw_enable = r_draw_enable;
  assign draw_over   = r_draw_over;
  assign busy        = r_busy;
  assign done        = r_done;
  assign plot_count  = r_plot_count;
  assign vga_plot    = r_tag_dl[LP_LAST];
  assign vga_x       = r_x_dl[LP_LAST];
  assign vga_y       = r_y_dl[LP_LAST];

  always_comb begin
    vga_colour = 24'd0;
    if (vga_plot) begin
      case (r_mode)
        2'd1:    vga_colour = colour_start;
        2'd2:    vga_colour = colour_over;
        default: vga_colour = colour_bg;
      endcase
    end
  end

endmodule
